kernel_window_mac: RTL and testbench
====================================

Name: kernel_window_mac

Overview:
Sequential kernel walker and multiply-accumulate unit for the corner and filter pipeline. It snapshots a pixel window and a signed coefficient kernel of runtime-selectable size, then visits one tap per cycle. Each cycle it multiplies the pixel by its coefficient and accumulates at full precision. The sum is delivered, saturated, through a valid/ready output handshake. It replaces strobe-driven single-tap indexing with a complete start/walk/deliver sequence.

Parameters:
MAX_KERNEL, 5, maximum kernel edge length (window is MAX_KERNEL x MAX_KERNEL)
PIX_W, 8, pixel width, unsigned
COEF_W, 8, coefficient width, two's complement
ACC_W, 16, output result width, signed, saturated

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
clear  in  1  synchronous abort, highest priority after reset
start  in  1  request a new accumulation (accepted only in IDLE)
ksize  in  $clog2(MAX_KERNEL+1)  active kernel edge k, legal range 1..MAX_KERNEL
window  in  MAX_KERNEL*MAX_KERNEL*PIX_W  pixels, indexed [row][col]
kernel  in  MAX_KERNEL*MAX_KERNEL*COEF_W  signed coefficients, indexed [row][col]
busy  out  1  high in ACCUM and DONE
err  out  1  one-cycle pulse when start is rejected for illegal ksize
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  ACC_W  signed saturated sum
sat  out  1  result was clamped (qualified by out_valid)

Behaviour:
- Reset is asynchronous on n_rst low; clock is clk. Reset state: state=IDLE; busy, err, out_valid, sat, result, accumulator, and row/col counters all 0.
- States: IDLE, ACCUM, DONE.
- IDLE, start=1, 1<=ksize<=MAX_KERNEL, on edge T:
  - register window, kernel and k into internal snapshot; later input changes have no effect.
  - row=col=0, acc=0, go to ACCUM.
- IDLE, start=1, ksize illegal (0 or >MAX_KERNEL): stay in IDLE; err=1 for exactly one cycle.
- ACCUM: each edge adds one term, acc += zext(pix[row][col]) * sext(coef[row][col]).
  - Product is signed, PIX_W+COEF_W+1 bits.
  - Accumulator width is PIX_W+COEF_W+1+2*$clog2(MAX_KERNEL); it never wraps.
  - Scan order: col increments fastest; at col=k-1, col resets to 0 and row increments.
  - The final term is at row=col=k-1. On that edge (T+k*k):
    - final sum is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and written to result;
    - sat=1 if clamped, else 0;
    - out_valid=1, go to DONE.
- Latency: start accepted at edge T, so out_valid rises after edge T+k*k (k=1: one cycle).
- DONE: result, sat and out_valid are held stable while out_ready=0. On an edge with out_valid & out_ready: out_valid=0, go to IDLE, busy=0 next cycle.
- start is ignored whenever busy=1, including the handshake cycle. A new start is accepted no earlier than the first cycle in IDLE.
- clear=1 in any state: next edge gives state=IDLE, out_valid=0, sat=0, result=0, acc=0, counters 0. start is ignored on that edge.
- n_rst low mid-ACCUM or in DONE: immediate return to reset state; the partial sum is discarded.
- Taps outside the k x k region are never read; their contents have no effect.
- err is 0 in all cycles except the rejection pulse.

Decomposition:
- Shared package kernel_pkg holds:
  - state enum typedef (IDLE, ACCUM, DONE);
  - localparam functions for product width and accumulator width;
  - ACC_MAX/ACC_MIN saturation constants derived from ACC_W.
- One natural sub-module, mac_sat_unit (combinational): multiply-add, then the saturating clamp with sat flag.
- Counters, snapshot registers and the FSM stay in kernel_window_mac.

Test Plan:
- ksize=3, all pixels 1, all coefs 1, start at T -> out_valid after edge T+9, result=9, sat=0, busy high edges T..handshake.
- ksize=3, center pixel 200, others 10; center coef 8, others -1 -> result=1520, sat=0. Window changed on the cycle after start -> result still 1520.
- ksize=5, pixels 255, coefs 127 -> result=32767, sat=1. Coefs -128 -> result=-32768, sat=1.
- out_ready held 0 for 5 cycles after out_valid, with start pulsed -> result/sat/out_valid stable, start ignored. out_ready=1 -> IDLE, busy=0 next cycle, out_valid=0.
- start with ksize=0, then ksize=6 -> err one-cycle pulse each time, busy stays 0, out_valid stays 0. ksize=1, pixel 7, coef -3 -> result=-21 after 1 cycle.
- n_rst low at 4th ACCUM cycle -> all outputs 0 immediately. clear mid-ACCUM -> IDLE next edge, and the following start runs a full fresh k*k accumulation.

Source files
------------

// File: rtl/kernel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_pkg
//  Description : Shared types, width helpers and saturation limits for the
//                kernel window multiply-accumulate walker.
//  Revision    : 1.0  initial release
// ============================================================================
package kernel_pkg;

    // Walker states: waiting for work, stepping through taps, holding result
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Signed product of an unsigned pixel and a signed coefficient
    function automatic int prod_width(input int pix_w, input int coef_w);
        return pix_w + coef_w + 1;
    endfunction

    // Full-precision accumulator: enough headroom for max_k*max_k products
    function automatic int acc_width(input int pix_w, input int coef_w, input int max_k);
        return prod_width(pix_w, coef_w) + 2 * $clog2(max_k);
    endfunction

    // Largest value representable in an acc_w-bit signed result
    function automatic longint acc_max(input int acc_w);
        return (longint'(1) <<< (acc_w - 1)) - 1;
    endfunction

    // Smallest value representable in an acc_w-bit signed result
    function automatic longint acc_min(input int acc_w);
        return -(longint'(1) <<< (acc_w - 1));
    endfunction

    localparam int     DEF_ACC_W = 16;
    localparam longint ACC_MAX   = acc_max(DEF_ACC_W);
    localparam longint ACC_MIN   = acc_min(DEF_ACC_W);

endpackage
`default_nettype wire

// File: rtl/mac_sat_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mac_sat_unit
//  Description : Combinational multiply-add of one pixel/coefficient tap onto
//                the running sum, plus a saturating clamp of that sum to the
//                output width with a clamp flag.
//  Revision    : 1.0  initial release
// ============================================================================
module mac_sat_unit
    import kernel_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 16,
    parameter int PROD_W = 17,
    parameter int SUM_W  = 23
) (
    input  logic signed [SUM_W-1:0]  acc_in,
    input  logic        [PIX_W-1:0]  pix,
    input  logic        [COEF_W-1:0] coef,
    output logic signed [SUM_W-1:0]  sum,
    output logic signed [ACC_W-1:0]  clamped,
    output logic                     sat
);

    localparam logic signed [SUM_W-1:0] c_sat_max = SUM_W'(acc_max(ACC_W));
    localparam logic signed [SUM_W-1:0] c_sat_min = SUM_W'(acc_min(ACC_W));

    logic [PROD_W-1:0] w_pix_ext;
    logic [PROD_W-1:0] w_coef_ext;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_prod_ext;

    // Pixel is unsigned, coefficient is two's complement; the low PROD_W
    // bits of the modular product equal the exact signed product.
    assign w_pix_ext  = {{(PROD_W-PIX_W){1'b0}}, pix};
    assign w_coef_ext = {{(PROD_W-COEF_W){coef[COEF_W-1]}}, coef};
    assign w_prod     = w_pix_ext * w_coef_ext;
    assign w_prod_ext = {{(SUM_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // Add the tap and clamp the new sum into the signed result range
    always_comb begin
        sum     = $signed(acc_in + $signed(w_prod_ext));
        clamped = sum[ACC_W-1:0];
        sat     = 1'b0;
        if (sum > c_sat_max) begin
            clamped = c_sat_max[ACC_W-1:0];
            sat     = 1'b1;
        end else if (sum < c_sat_min) begin
            clamped = c_sat_min[ACC_W-1:0];
            sat     = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/kernel_window_mac.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_window_mac
//  Description : Snapshots a pixel window and signed kernel of runtime size k,
//                walks the k x k taps one per cycle accumulating at full
//                precision, and delivers the saturated sum over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module kernel_window_mac
    import kernel_pkg::*;
#(
    parameter  int MAX_KERNEL = 5,
    parameter  int PIX_W      = 8,
    parameter  int COEF_W     = 8,
    parameter  int ACC_W      = 16,
    localparam int KS_W       = $clog2(MAX_KERNEL + 1)
) (
    input  logic                                    clk,
    input  logic                                    n_rst,
    input  logic                                    clear,
    input  logic                                    start,
    input  logic [KS_W-1:0]                         ksize,
    input  logic [MAX_KERNEL*MAX_KERNEL*PIX_W-1:0]  window,
    input  logic [MAX_KERNEL*MAX_KERNEL*COEF_W-1:0] kernel,
    output logic                                    busy,
    output logic                                    err,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic signed [ACC_W-1:0]                 result,
    output logic                                    sat
);

    localparam int CNT_W  = (MAX_KERNEL > 1) ? $clog2(MAX_KERNEL) : 1;
    localparam int PROD_W = prod_width(PIX_W, COEF_W);
    localparam int SUM_W  = acc_width(PIX_W, COEF_W, MAX_KERNEL);

    state_t                                  r_state;
    state_t                                  w_state_nxt;
    logic [MAX_KERNEL*MAX_KERNEL*PIX_W-1:0]  r_win;
    logic [MAX_KERNEL*MAX_KERNEL*COEF_W-1:0] r_ker;
    logic [CNT_W-1:0]                        r_last;
    logic [CNT_W-1:0]                        r_row;
    logic [CNT_W-1:0]                        r_col;
    logic signed [SUM_W-1:0]                 r_acc;

    logic                    w_legal;
    logic                    w_last_tap;
    logic                    w_accept;
    logic                    w_reject;
    logic                    w_step;
    logic                    w_finish;
    logic                    w_handoff;
    logic [PIX_W-1:0]        w_pix_tap  [MAX_KERNEL][MAX_KERNEL];
    logic [COEF_W-1:0]       w_coef_tap [MAX_KERNEL][MAX_KERNEL];
    logic signed [SUM_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_clamped;
    logic                    w_sat;

    // Unpack the snapshot into [row][col] tap arrays
    generate
        for (genvar gr = 0; gr < MAX_KERNEL; gr++) begin : g_row
            for (genvar gc = 0; gc < MAX_KERNEL; gc++) begin : g_col
                assign w_pix_tap[gr][gc]  = r_win[(gr*MAX_KERNEL+gc)*PIX_W  +: PIX_W];
                assign w_coef_tap[gr][gc] = r_ker[(gr*MAX_KERNEL+gc)*COEF_W +: COEF_W];
            end
        end
    endgenerate

    assign w_legal    = (ksize != '0) && (ksize <= KS_W'(MAX_KERNEL));
    assign w_last_tap = (r_row == r_last) && (r_col == r_last);

    mac_sat_unit #(
        .PIX_W  (PIX_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W),
        .SUM_W  (SUM_W)
    ) u_mac (
        .acc_in  (r_acc),
        .pix     (w_pix_tap[r_row][r_col]),
        .coef    (w_coef_tap[r_row][r_col]),
        .sum     (w_sum),
        .clamped (w_clamped),
        .sat     (w_sat)
    );

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        w_handoff   = 1'b0;
        busy        = (r_state != ST_IDLE);
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_legal) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_ACCUM;
                        end else begin
                            w_reject = 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    w_step = 1'b1;
                    if (w_last_tap) begin
                        w_finish    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_handoff   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Snapshot, tap counters, accumulator and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_win     <= '0;
            r_ker     <= '0;
            r_last    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_acc     <= '0;
            result    <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else if (clear) begin
            r_row     <= '0;
            r_col     <= '0;
            r_acc     <= '0;
            result    <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= w_reject;
            if (w_accept) begin
                r_win  <= window;
                r_ker  <= kernel;
                r_last <= CNT_W'(ksize - KS_W'(1));
                r_row  <= '0;
                r_col  <= '0;
                r_acc  <= '0;
            end
            if (w_step) begin
                r_acc <= w_sum;
                if (w_finish) begin
                    r_row     <= '0;
                    r_col     <= '0;
                    result    <= w_clamped;
                    sat       <= w_sat;
                    out_valid <= 1'b1;
                end else if (r_col == r_last) begin
                    r_col <= '0;
                    r_row <= r_row + CNT_W'(1);
                end else begin
                    r_col <= r_col + CNT_W'(1);
                end
            end
            if (w_handoff) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kernel_window_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kernel_window_mac
//  Description : Scoreboard bench for kernel_window_mac with a sum-of-products
//                reference model, directed corner cases and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_kernel_window_mac;

    logic                clk = 1'b0;
    logic                n_rst;
    logic                clear;
    logic                start;
    logic [2:0]          ksize;
    logic [199:0]        window;
    logic [199:0]        kernel;
    logic                busy;
    logic                err;
    logic                out_valid;
    logic                out_ready;
    logic signed [15:0]  result;
    logic                sat;

    int          total = 0;
    int          bad   = 0;
    logic [16:0] exp_q [$];
    logic [16:0] mon_e;
    int          pix  [5][5];
    int          coef [5][5];

    kernel_window_mac dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .start     (start),
        .ksize     (ksize),
        .window    (window),
        .kernel    (kernel),
        .busy      (busy),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain sum over the k x k taps, then clamp to 16-bit signed
    function automatic logic [16:0] model(input int k);
        longint             s = 0;
        logic               f = 1'b0;
        logic signed [15:0] r;
        for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
                s += longint'(pix[i][j]) * longint'(coef[i][j]);
        if (s > 32767) begin
            s = 32767; f = 1'b1;
        end else if (s < -32768) begin
            s = -32768; f = 1'b1;
        end
        r = 16'(s);
        return {f, r};
    endfunction

    task automatic fill(input int p_in, input int c_in, input int p_ctr, input int c_ctr);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                pix[i][j]  = p_in;
                coef[i][j] = c_in;
            end
        pix[1][1]  = p_ctr;
        coef[1][1] = c_ctr;
    endtask

    task automatic apply_arrays();
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                window[(i*5+j)*8 +: 8] = 8'(pix[i][j]);
                kernel[(i*5+j)*8 +: 8] = 8'(coef[i][j]);
            end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 25; i++) begin
            window[i*8 +: 8] = 8'($urandom);
            kernel[i*8 +: 8] = 8'($urandom);
        end
    endtask

    // One full transaction: start, walk, optional back-pressure, handshake
    task automatic run_txn(input int k, input int hold, input bit pulse);
        int                 n = 0;
        bit                 seen = 0;
        logic signed [15:0] r0;
        logic               s0;
        exp_q.push_back(model(k));
        apply_arrays();
        ksize = 3'(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        scramble_inputs();
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1;
            else if (n == 1) check("busy_accum", busy, 1);
        end
        check("latency", seen ? n : -1, k*k + 1);
        if (!seen) return;
        r0 = result;
        s0 = sat;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            start = pulse;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, r0);
            check("hold_sat", sat, s0);
            check("hold_busy", busy, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        start     = pulse;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        check("post_hs_busy", busy, 0);
        check("post_hs_valid", out_valid, 0);
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
    endtask

    task automatic reject(input int k);
        ksize = 3'(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        @(posedge clk); #1;
        check("err_clear", err, 0);
        check("err_valid", out_valid, 0);
        check("err_busy2", busy, 0);
    endtask

    // Monitor: compare every delivered result against the scoreboard head
    always @(negedge clk) begin
        if (n_rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", result, $signed(mon_e[15:0]));
                check("sat", sat, mon_e[16]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; clear = 1'b0; start = 1'b0; out_ready = 1'b0;
        ksize = 3'd0; window = '0; kernel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sat", sat, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;

        fill(1, 1, 1, 1);        run_txn(3, 0, 0);
        fill(10, -1, 200, 8);    run_txn(3, 0, 0);
        fill(255, 127, 255, 127); run_txn(5, 0, 0);
        fill(255, -128, 255, -128); run_txn(5, 0, 0);
        fill(3, 5, 9, -7);       run_txn(4, 5, 1);
        reject(0);
        reject(6);
        reject(7);
        fill(7, -3, 7, -3);      run_txn(1, 0, 0);

        // Asynchronous reset during the fourth accumulation cycle
        fill(20, 30, 40, 50);
        apply_arrays();
        ksize = 3'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_result", result, 0);
        check("arst_sat", sat, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Clear mid-walk with a simultaneous start that must be ignored
        fill(4, 6, 8, -9);       run_txn(2, 0, 0);
        fill(50, 60, 70, 80);
        apply_arrays();
        ksize = 3'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(model(3));
        @(posedge clk); #1;
        clear = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; start = 1'b0;
        void'(exp_q.pop_back());
        check("clr_busy", busy, 0);
        check("clr_valid", out_valid, 0);
        check("clr_result", result, 0);
        check("clr_sat", sat, 0);
        @(posedge clk); #1;
        check("clr_start_ignored", busy, 0);
        fill(2, 3, 11, -4);      run_txn(3, 1, 0);

        // Random traffic; taps outside k x k are randomised too
        for (int t = 0; t < 25; t++) begin
            int mode = $urandom_range(0, 3);
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) begin
                    pix[i][j]  = (mode == 1) ? 255 : $urandom_range(0, 255);
                    coef[i][j] = (mode == 1) ? 127 : (mode == 2) ? -128
                                 : $urandom_range(0, 255) - 128;
                end
            run_txn($urandom_range(1, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
